seq_monitor: RTL
================

SEQ_MONITOR -- requirements
Module: seq_monitor

Interface
REQ-001 Parameter MIN_P1, default 200: minimum cycles held in phase P1 (mem released, pe held).
REQ-002 Parameter MIN_P2, default 4000: minimum cycles held in phase P2.
REQ-003 Parameter MIN_P3, default 2000: minimum cycles held in phase P3.
REQ-004 Parameter MIN_P4, default 2000: minimum cycles held in phase P4.
REQ-005 clk  input  1  sole clock, all logic on posedge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 rst_mem_i, rst_pe_i, rst_3b3_i, rst_2b2_i  input  1 each  stage resets from the sequencer; 1 = held, release = 1->0.
REQ-008 rst_disp_i  input  1  display enable from the sequencer; release = 0->1.
REQ-009 phase  output  3  current tracked phase, 0..5, or 7 = ERR.
REQ-010 start_pulse  output  5  one-cycle pulse per legal release, bit0 mem, bit1 pe, bit2 3b3, bit3 2b2, bit4 disp.
REQ-011 last_cycles  output  32  length in cycles of the most recently completed phase.
REQ-012 done  output  1  high while phase = 5.
REQ-013 order_err  output  1  sticky ordering violation flag.
REQ-014 err_phase  output  3  phase in which the first ordering violation occurred.
REQ-015 timing_err  output  1  sticky minimum-duration violation flag.

Function
REQ-016 The block SHALL register all five inputs once (sample register s) and hold the previous sample (register p); event = s differs from p.
REQ-017 An input change before edge N SHALL be reflected in phase, start_pulse and last_cycles after edge N+1 (two-cycle latency).
REQ-018 FSM states: P0 all held, P1..P4 after release of mem/pe/3b3/2b2 respectively, P5 after disp asserted, ERR.
REQ-019 In Pk (k = 0..4), when the only event is the expected release of line k, the block SHALL advance to Pk+1 and pulse start_pulse[k] for exactly one cycle.
REQ-020 Any other event in P0..P5 SHALL move to ERR, set order_err, and load err_phase with the current phase: out-of-order release, re-assertion of a released line, two or more simultaneous events, or any event in P5.
REQ-021 ERR SHALL be terminal until rst, with no start_pulse generated there.
REQ-022 A 32-bit phase counter SHALL clear on phase entry, increment each cycle, and saturate at 0xFFFFFFFF.
REQ-023 On each legal transition, last_cycles SHALL load counter+1, saturating, which equals the number of cycles the phase was held.
REQ-024 done SHALL equal (phase == 5).

Reset
REQ-025 While rst = 1 at a posedge: phase = 0, start_pulse = 0, last_cycles = 0, done = 0, order_err = 0, err_phase = 0, timing_err = 0, and counter = 0.
REQ-026 At reset, s and p SHALL load the idle pattern (four resets = 1, disp = 0), so any line already released after reset is detected as an event.
REQ-027 rst asserted mid-sequence or in ERR SHALL return the block to P0 on the same edge.

Configuration
REQ-028 Macro SEQ_MON_TIMING_CHECK_EN defined: on leaving Pk (k = 1..4) with last_cycles < MIN_Pk, timing_err SHALL set (sticky) while the FSM still advances normally.
REQ-029 Macro SEQ_MON_TIMING_CHECK_EN undefined: timing_err SHALL be constant 0 and no comparators are built.

Verification
REQ-030 The bench SHALL drive the nominal sequence with gaps of 201/4001/2001/2001 cycles -> pulses bits 0..4 in order, last_cycles = 201, 4001, 2001, 2001, done = 1, and both error flags = 0.
REQ-031 The bench SHALL release pe before mem -> phase = 7, order_err = 1, err_phase = 0, and no pulses.
REQ-032 The bench SHALL release 3b3 and 2b2 on the same cycle while in P2 -> ERR, err_phase = 2.
REQ-033 With the macro defined, the bench SHALL release pe 100 cycles after mem -> timing_err = 1, phase = 2, last_cycles = 100; without the macro, timing_err = 0.
REQ-034 The bench SHALL assert rst for 1 cycle while in P3 -> all outputs return to reset values, then a full legal sequence completes with done = 1.
REQ-035 The bench SHALL re-assert rst_mem_i while in P5 -> ERR, err_phase = 5, and done = 0.

Source files
------------

// File: rtl/seq_monitor.sv
// seq_monitor: watches the power-up reset sequencer and tracks its phase.
// Stage resets (mem, pe, 3b3, 2b2) must release in order, then disp asserts.
// Reports per-release pulses, the length of each completed phase and
// sticky ordering errors.
// Optional macro SEQ_MON_TIMING_CHECK_EN adds minimum phase-length checking.
module seq_monitor #(
    parameter int unsigned MIN_P1 = 200,
    parameter int unsigned MIN_P2 = 4000,
    parameter int unsigned MIN_P3 = 2000,
    parameter int unsigned MIN_P4 = 2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rst_mem_i,
    input  logic        rst_pe_i,
    input  logic        rst_3b3_i,
    input  logic        rst_2b2_i,
    input  logic        rst_disp_i,
    output logic [2:0]  phase,
    output logic [4:0]  start_pulse,
    output logic [31:0] last_cycles,
    output logic        done,
    output logic        order_err,
    output logic [2:0]  err_phase,
    output logic        timing_err
);

    typedef enum logic [2:0] {
        P0  = 3'd0,
        P1  = 3'd1,
        P2  = 3'd2,
        P3  = 3'd3,
        P4  = 3'd4,
        P5  = 3'd5,
        ERR = 3'd7
    } state_t;

    // Bit order {disp, 2b2, 3b3, pe, mem}; idle = all stages held, display off.
    localparam logic [4:0] IDLE = 5'b01111;

    state_t      state;
    logic [4:0]  s;
    logic [4:0]  p;
    logic [4:0]  ev;
    logic [31:0] cnt;
    logic [31:0] cnt_inc;
    logic        legal;

    // Sample the sequencer lines and keep the previous sample for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            s <= IDLE;
            p <= IDLE;
        end else begin
            s <= {rst_disp_i, rst_2b2_i, rst_3b3_i, rst_pe_i, rst_mem_i};
            p <= s;
        end
    end

    // Event decode: legal only when the single expected line moves the right way.
    always_comb begin
        ev      = s ^ p;
        cnt_inc = (cnt == '1) ? cnt : cnt + 32'd1;
        legal   = 1'b0;
        case (state)
            P0:      legal = (ev == 5'b00001) && !s[0];
            P1:      legal = (ev == 5'b00010) && !s[1];
            P2:      legal = (ev == 5'b00100) && !s[2];
            P3:      legal = (ev == 5'b01000) && !s[3];
            P4:      legal = (ev == 5'b10000) &&  s[4];
            default: legal = 1'b0;
        endcase
    end

    // Phase FSM with registered pulses, phase length and error capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= P0;
            start_pulse <= '0;
            last_cycles <= '0;
            done        <= 1'b0;
            order_err   <= 1'b0;
            err_phase   <= '0;
            cnt         <= '0;
        end else begin
            start_pulse <= '0;
            if (state != ERR && ev != '0) begin
                cnt <= '0;
                if (legal) begin
                    state       <= state_t'(state + 3'd1);
                    start_pulse <= 5'b00001 << state;
                    last_cycles <= cnt_inc;
                    done        <= (state == P4);
                end else begin
                    state     <= ERR;
                    order_err <= 1'b1;
                    err_phase <= state;
                    done      <= 1'b0;
                end
            end else begin
                cnt <= cnt_inc;
            end
        end
    end

    always_comb phase = state;

`ifdef SEQ_MON_TIMING_CHECK_EN
    logic [31:0] min_cur;

    // Minimum hold time of the phase currently being tracked.
    always_comb begin
        case (state)
            P1:      min_cur = MIN_P1;
            P2:      min_cur = MIN_P2;
            P3:      min_cur = MIN_P3;
            P4:      min_cur = MIN_P4;
            default: min_cur = '0;
        endcase
    end

    // Sticky flag when a phase is left early; the FSM still advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            timing_err <= 1'b0;
        end else if (legal && (cnt_inc < min_cur)) begin
            timing_err <= 1'b1;
        end
    end
`else
    // Minimums are referenced only to keep them live; this folds to 0.
    assign timing_err = 1'b0 & (|{MIN_P1, MIN_P2, MIN_P3, MIN_P4});
`endif

endmodule
